// File: rtl/nes_pkg.sv
`default_nettype none
// ============================================================================
// Package  : nes_pkg
// Purpose  : Shared types and constants for the NES core blocks.
// Revision : 1.0 - initial release
// ============================================================================
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
    localparam int          OAM_BYTES    = 256;

endpackage
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_ctrl
// Purpose  : Sprite OAM DMA sequencer; halts the CPU and copies one RAM page
//            into OAM starting at the latched OAMADDR offset.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma_ctrl
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_ADDR,
    parameter bit          ALIGN_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    input  logic [7:0]  oam_base,
    input  logic [7:0]  ram_dout,
    output logic [15:0] ram_addr,
    output logic        ram_sel,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_din,
    output logic        oam_wren,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] c_LAST_IDX = 8'(OAM_BYTES - 1);

    dma_state_t r_state;
    dma_state_t w_next_state;
    logic [7:0] r_page;
    logic [7:0] r_base;
    logic [7:0] r_idx;
    logic       r_cyc_par;
    logic       r_done;
    logic       w_trigger;
    logic       w_last;

    assign w_trigger = cpu_wr && (cpu_addr == DMA_REG_ADDR);
    assign w_last    = (r_idx == c_LAST_IDX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_page    <= '0;
            r_base    <= '0;
            r_idx     <= '0;
            r_cyc_par <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cyc_par <= ~r_cyc_par;
            r_done    <= (r_state == WRITE) && w_last;
            // base is captured here so OAMADDR writes mid-transfer cannot skew the copy
            if ((r_state == IDLE) && w_trigger) begin
                r_page <= cpu_dout;
                r_base <= oam_base;
                r_idx  <= '0;
            end else if ((r_state == WRITE) && !w_last) begin
                r_idx  <= r_idx + 8'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_trigger) w_next_state = HALT;
            HALT:    w_next_state = (ALIGN_EN && r_cyc_par) ? ALIGN : READ;
            ALIGN:   w_next_state = READ;
            READ:    w_next_state = WRITE;
            WRITE:   w_next_state = w_last ? IDLE : READ;
            default: w_next_state = IDLE;
        endcase
    end

    // ram_dout already carries the byte addressed in the preceding READ cycle
    assign busy       = (r_state != IDLE);
    assign ram_sel    = busy;
    assign cpu_enable = (r_state == IDLE);
    assign oam_wren   = (r_state == WRITE);
    assign ram_addr   = busy ? {r_page, r_idx} : 16'h0000;
    assign oam_addr   = oam_wren ? (r_base + r_idx) : 8'h00;
    assign oam_din    = oam_wren ? ram_dout : 8'h00;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_dma_ctrl
// Purpose  : Directed self-checking bench for oam_dma_ctrl with RAM/OAM models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  oam_base;
    logic [7:0]  ram_dout = 8'h00;
    logic [15:0] ram_addr;
    logic        ram_sel;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_din;
    logic        oam_wren;
    logic        cpu_enable;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ram [0:65535];
    logic [7:0] oam [0:255];
    logic       oam_clr = 1'b0;
    logic       par = 1'b0;

    oam_dma_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_wr     (cpu_wr),
        .oam_base   (oam_base),
        .ram_dout   (ram_dout),
        .ram_addr   (ram_addr),
        .ram_sel    (ram_sel),
        .oam_addr   (oam_addr),
        .oam_din    (oam_din),
        .oam_wren   (oam_wren),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Synchronous work RAM and OAM port-1 models
    always @(posedge clk) begin
        ram_dout <= ram[ram_addr];
        if (oam_clr) begin
            for (int i = 0; i < 256; i++) oam[i] <= 8'hEE;
        end else if (oam_wren) begin
            oam[oam_addr] <= oam_din;
        end
    end

    // Expected CPU-cycle parity: cleared by reset, toggles on every other edge
    always @(posedge clk) par <= reset_n ? ~par : 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] f2(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] f3(input int i);
        return 8'(i * 7 + 17);
    endfunction

    function automatic int oam_errs(input bit pg3, input logic [7:0] base, input int lo, input int hi);
        int e = 0;
        for (int i = lo; i <= hi; i++) begin
            logic [7:0] a = base + 8'(i);
            if (oam[a] !== (pg3 ? f3(i) : f2(i))) e++;
        end
        return e;
    endfunction

    task automatic clear_oam();
        oam_clr = 1'b1;
        @(negedge clk);
        oam_clr = 1'b0;
    endtask

    // Wait until the cycle right after the trigger edge (HALT) will see cyc_par == want
    task automatic align_par(input logic want);
        while (par != ~want) @(negedge clk);
    endtask

    task automatic trigger(input logic [7:0] pg, input logic [7:0] ob);
        cpu_addr = 16'h4014;
        cpu_dout = pg;
        cpu_wr   = 1'b1;
        oam_base = ob;
        @(negedge clk);
        cpu_wr   = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic drain(input logic [7:0] pg, input int poke_at,
                         output int cyc, output int wr, output int bad, output int dn);
        cyc = 0; wr = 0; bad = 0; dn = 0;
        while (busy && cyc < 700) begin
            cyc++;
            if (oam_wren) wr++;
            if (ram_addr[15:8] != pg) bad++;
            if (done) dn++;
            if (cyc == poke_at) begin
                cpu_addr = 16'h4014;
                cpu_dout = 8'h05;
                cpu_wr   = 1'b1;
            end else if (cyc == poke_at + 1) begin
                cpu_wr   = 1'b0;
                cpu_addr = 16'h0000;
            end
            @(negedge clk);
        end
        if (busy) check_eq("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc, wr, bad, dn, k, exp_cyc;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ram[16'h0200 + i] = f2(i);
            ram[16'h0300 + i] = f3(i);
            ram[16'h0500 + i] = 8'hC3;
        end
        reset_n = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_dout = 8'h00; oam_base = 8'h00;

        // 1: reset state and non-trigger writes
        repeat (3) @(negedge clk);
        check_eq("rst_cpu_enable", 32'(cpu_enable), 32'd1);
        check_eq("rst_busy",       32'(busy),       32'd0);
        check_eq("rst_ram_sel",    32'(ram_sel),    32'd0);
        check_eq("rst_oam_wren",   32'(oam_wren),   32'd0);
        check_eq("rst_done",       32'(done),       32'd0);
        check_eq("rst_ram_addr",   32'(ram_addr),   32'd0);
        check_eq("rst_oam_out",    {16'd0, oam_addr, oam_din}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        cpu_addr = 16'h4015; cpu_dout = 8'h02; cpu_wr = 1'b1;
        @(negedge clk);
        check_eq("ign_4015", 32'(busy), 32'd0);
        cpu_addr = 16'h2003;
        @(negedge clk);
        check_eq("ign_2003", 32'(busy), 32'd0);
        cpu_wr = 1'b0; cpu_addr = 16'h0000;

        // 2: even start, 513 cycles
        clear_oam();
        align_par(1'b0);
        trigger(8'h02, 8'h00);
        check_eq("t2_cpu_halted", 32'(cpu_enable), 32'd0);
        drain(8'h02, -1, cyc, wr, bad, dn);
        check_eq("t2_busy_cycles", 32'(cyc), 32'd513);
        check_eq("t2_wren_count",  32'(wr),  32'd256);
        check_eq("t2_page_const",  32'(bad), 32'd0);
        check_eq("t2_done_early",  32'(dn),  32'd0);
        check_eq("t2_done_pulse",  32'(done), 32'd1);
        check_eq("t2_cpu_resumed", 32'(cpu_enable), 32'd1);
        check_eq("t2_oam_errs",    32'(oam_errs(1'b0, 8'h00, 0, 255)), 32'd0);
        @(negedge clk);
        check_eq("t2_done_clear",  32'(done), 32'd0);

        // 3: odd start inserts ALIGN
        clear_oam();
        align_par(1'b1);
        trigger(8'h02, 8'h00);
        drain(8'h02, -1, cyc, wr, bad, dn);
        check_eq("t3_busy_cycles", 32'(cyc), 32'd514);
        check_eq("t3_wren_count",  32'(wr),  32'd256);
        check_eq("t3_done_pulse",  32'(done), 32'd1);
        check_eq("t3_oam_errs",    32'(oam_errs(1'b0, 8'h00, 0, 255)), 32'd0);

        // 4: OAMADDR offset wraps; later oam_base changes are ignored
        clear_oam();
        align_par(1'b0);
        trigger(8'h03, 8'hFC);
        oam_base = 8'h00;
        drain(8'h03, -1, cyc, wr, bad, dn);
        check_eq("t4_busy_cycles", 32'(cyc), 32'd513);
        check_eq("t4_oam_FC", 32'(oam[8'hFC]), 32'h11);
        check_eq("t4_oam_FF", 32'(oam[8'hFF]), 32'h26);
        check_eq("t4_oam_00", 32'(oam[8'h00]), 32'h2D);
        check_eq("t4_oam_FB", 32'(oam[8'hFB]), 32'h0A);
        check_eq("t4_oam_errs", 32'(oam_errs(1'b1, 8'hFC, 0, 255)), 32'd0);

        // 5: reset lands on the edge after byte 99 is written (READ of idx 100)
        clear_oam();
        align_par(1'b0);
        trigger(8'h02, 8'h00);
        k = 0;
        while (!(oam_wren && oam_addr == 8'd99) && k < 600) begin
            @(negedge clk);
            k++;
        end
        check_eq("t5_reach_99", 32'(oam_wren && oam_addr == 8'd99), 32'd1);
        @(negedge clk);
        check_eq("t5_read_100", 32'(ram_addr), 32'h0264);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("t5_cpu_enable", 32'(cpu_enable), 32'd1);
        check_eq("t5_busy",       32'(busy),       32'd0);
        check_eq("t5_oam_wren",   32'(oam_wren),   32'd0);
        reset_n = 1'b1;
        wr = 0;
        repeat (5) begin
            @(negedge clk);
            if (oam_wren) wr++;
        end
        check_eq("t5_no_wren", 32'(wr), 32'd0);
        check_eq("t5_written", 32'(oam_errs(1'b0, 8'h00, 0, 99)), 32'd0);
        bad = 0;
        for (int i = 100; i < 256; i++) if (oam[i] !== 8'hEE) bad++;
        check_eq("t5_untouched", 32'(bad), 32'd0);
        align_par(1'b0);
        trigger(8'h03, 8'h00);
        drain(8'h03, -1, cyc, wr, bad, dn);
        check_eq("t5_restart_cycles", 32'(cyc), 32'd513);
        check_eq("t5_restart_oam", 32'(oam_errs(1'b1, 8'h00, 0, 255)), 32'd0);

        // 6: re-trigger while busy is ignored; trigger in the done cycle is taken
        align_par(1'b0);
        trigger(8'h02, 8'h00);
        drain(8'h02, 20, cyc, wr, bad, dn);
        check_eq("t6_busy_cycles", 32'(cyc), 32'd513);
        check_eq("t6_page_kept",   32'(bad), 32'd0);
        check_eq("t6_done_pulse",  32'(done), 32'd1);
        exp_cyc = (par == 1'b0) ? 514 : 513;
        trigger(8'h03, 8'h00);
        check_eq("t6_retrig_halt", {30'd0, busy, cpu_enable}, 32'd2);
        check_eq("t6_retrig_addr", 32'(ram_addr), 32'h0300);
        check_eq("t6_done_clear",  32'(done), 32'd0);
        drain(8'h03, -1, cyc, wr, bad, dn);
        check_eq("t6_second_cycles", 32'(cyc), 32'(exp_cyc));
        check_eq("t6_second_oam", 32'(oam_errs(1'b1, 8'h00, 0, 255)), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
